// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three bus faces of the memory arbiter:
//   fetch port : if_req, if_addr -> if_gnt, if_rvalid, if_rdata, if_err
//   data port  : d_req, d_we, d_wmask, d_addr, d_wdata
//                -> d_gnt, d_rvalid, d_rdata, d_err
//   memory     : mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// Modports:
//   slave  : the arbiter (consumes requests and read data, drives the rest)
//   master : the requesters plus memory model (the opposite directions)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 8
);
   logic              if_req;
   logic [31:0]       if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              if_err;

   logic              d_req;
   logic              d_we;
   logic [3:0]        d_wmask;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              d_err;

   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  d_req, d_we, d_wmask, d_addr, d_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata, if_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output d_req, d_we, d_wmask, d_addr, d_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous memory between an instruction-fetch port
// and a load/store port. One request is granted per cycle (combinational
// grant); data has priority unless fetch has been denied STARVE_MAX cycles in
// a row. Reads answer one cycle after grant; out-of-range accesses are granted
// but never touch memory and answer with an error instead.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.slave (fetch, data and memory signal groups)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int STARVE_MAX = 3
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;
   logic             pend_if;
   logic             pend_d;
   logic             rsp_err_p1;
   logic             st_err_p1;

   logic             fetch_wins;
   logic             any_gnt;
   logic             is_store;
   logic             in_range;
   logic [31:0]      sel_addr;

   // ---- stage 0: arbitration and memory command (combinational) ----
   always_comb begin
      fetch_wins    = bus.if_req && (!bus.d_req || (starve_cnt == STARVE_LIM));
      bus.if_gnt    = !reset && fetch_wins;
      bus.d_gnt     = !reset && bus.d_req && !fetch_wins;
      any_gnt       = bus.if_gnt || bus.d_gnt;
      is_store      = bus.d_gnt && bus.d_we;
      sel_addr      = bus.if_gnt ? bus.if_addr : bus.d_addr;
      // Anything above the word-address field makes the access out of range.
      in_range      = ((sel_addr >> (ADDR_W + 2)) == 32'd0);

      bus.mem_en    = any_gnt && in_range;
      bus.mem_we    = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (bus.mem_en) begin
         bus.mem_addr = sel_addr[ADDR_W+1:2];
         if (is_store) begin
            bus.mem_we    = bus.d_wmask;
            bus.mem_wdata = bus.d_wdata;
         end
      end
   end

   // ---- stage 0 -> 1: starvation counter and response ownership ----
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
         pend_if    <= 1'b0;
         pend_d     <= 1'b0;
         rsp_err_p1 <= 1'b0;
         st_err_p1  <= 1'b0;
      end else begin
         if (!bus.if_req || bus.if_gnt)
            starve_cnt <= '0;
         else if (starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + CNT_W'(1);
         pend_if    <= bus.if_gnt;
         pend_d     <= bus.d_gnt && !bus.d_we;
         rsp_err_p1 <= any_gnt && !is_store && !in_range;
         st_err_p1  <= is_store && !in_range;
      end
   end

   // ---- stage 1: responses ----
   // Gating with reset squashes a response whose grant happened the cycle
   // before reset was raised; the flags themselves clear at the reset edge.
   always_comb begin
      bus.if_rvalid = pend_if && !reset;
      bus.if_err    = bus.if_rvalid && rsp_err_p1;
      bus.if_rdata  = (bus.if_rvalid && !rsp_err_p1) ? bus.mem_rdata : 32'd0;

      bus.d_rvalid  = pend_d && !reset;
      bus.d_err     = (bus.d_rvalid && rsp_err_p1) || (st_err_p1 && !reset);
      bus.d_rdata   = (bus.d_rvalid && !rsp_err_p1) ? bus.mem_rdata : 32'd0;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;

   mem_arbiter_if #(.ADDR_W(AW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   typedef struct {
      logic        is_d;
      logic        rvalid;
      logic        err;
      logic [31:0] data;
      int          due;
   } rsp_t;
   rsp_t exp_q[$];

   // Synchronous single-port memory driven by the arbiter
   always @(posedge clk) begin
      logic [31:0] nw;
      if (bus.mem_en) begin
         if (bus.mem_we == 4'd0) begin
            bus.mem_rdata <= mem[bus.mem_addr];
         end else begin
            nw = mem[bus.mem_addr];
            for (int i = 0; i < 4; i++)
               if (bus.mem_we[i]) nw[8*i +: 8] = bus.mem_wdata[8*i +: 8];
            mem[bus.mem_addr] <= nw;
         end
      end
   end

   // Response scoreboard: every visible response must match the queue head
   always @(negedge clk) begin
      logic [67:0] got, want;
      rsp_t e;
      got = {bus.if_rvalid, bus.if_err, bus.if_rdata, bus.d_rvalid, bus.d_err, bus.d_rdata};
      if (bus.if_rvalid || bus.if_err || bus.d_rvalid || bus.d_err) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected cyc=%0d: got %h, expected no response", cyc, got);
         end else begin
            e = exp_q.pop_front();
            want = e.is_d ? {34'd0, e.rvalid, e.err, e.data} : {e.rvalid, e.err, e.data, 34'd0};
            if (got !== want || cyc != e.due) begin
               n_err++;
               $display("FAIL rsp_data cyc=%0d: got %h, expected %h at cyc %0d", cyc, got, want, e.due);
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         n_vec++;
         n_err++;
         e = exp_q.pop_front();
         $display("FAIL rsp_missing cyc=%0d: got no response, expected data %h err %b", cyc, e.data, e.err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                        input logic [3:0] dwm, input logic [31:0] da, input logic [31:0] dwd);
      bus.if_req  = ir;
      bus.if_addr = ia;
      bus.d_req   = dr;
      bus.d_we    = dwe;
      bus.d_wmask = dwm;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
   endtask

   // Reference model of one predicted grant in the current cycle
   task automatic expect_access(input logic is_if, input logic we, input logic [3:0] wm,
                                input logic [31:0] addr, input logic [31:0] wd);
      logic          in_r;
      logic [AW-1:0] w;
      rsp_t          e;
      in_r = ((addr >> (AW + 2)) == 32'd0);
      w    = addr[AW+1:2];
      e.is_d = !is_if;
      e.due  = cyc + 1;
      if (we) begin
         if (in_r) begin
            for (int i = 0; i < 4; i++)
               if (wm[i]) ref_mem[w][8*i +: 8] = wd[8*i +: 8];
         end else begin
            e.rvalid = 1'b0;
            e.err    = 1'b1;
            e.data   = 32'd0;
            exp_q.push_back(e);
         end
      end else begin
         e.rvalid = 1'b1;
         e.err    = !in_r;
         e.data   = in_r ? ref_mem[w] : 32'd0;
         exp_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 32'h8, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
              bus.if_rvalid, bus.if_err, bus.if_rdata, bus.d_rvalid, bus.d_err, bus.d_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got gnt=%b%b mem_en=%b rvalid=%b%b err=%b%b, expected all 0",
                     bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err);
         end
         tick();
      end
      @(negedge clk);
      n_vec++;
      if ({dut.starve_cnt, dut.pend_if, dut.pend_d} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got starve=%0d pend_if=%b pend_d=%b, expected 0 0 0",
                  dut.starve_cnt, dut.pend_if, dut.pend_d);
      end
      tick();
   endtask

   task automatic test_fetch();
      logic [31:0] addrs [2];
      addrs[0] = 32'h8;
      addrs[1] = 32'hB;   // low bits ignored: same word
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, addrs[k], 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         @(negedge clk);
         n_vec++;
         if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b101, 4'h0, 8'd2}) begin
            n_err++;
            $display("FAIL fetch_grant%0d: got gnt=%b%b en=%b we=%h addr=%0d, expected 10 1 0 2",
                     k, bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
         end
         expect_access(1'b1, 1'b0, 4'h0, addrs[k], 32'h0);
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      tick();
   endtask

   task automatic test_store_load();
      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hAABBCCDD);
      @(negedge clk);
      n_vec++;
      if ({bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}
          !== {3'b101, 4'b0011, 8'd4, 32'hAABBCCDD}) begin
         n_err++;
         $display("FAIL store_cmd: got gnt=%b en=%b we=%b addr=%0d wdata=%h, expected 1 1 0011 4 aabbccdd",
                  bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      expect_access(1'b0, 1'b1, 4'b0011, 32'h10, 32'hAABBCCDD);
      tick();

      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h14, 32'h12345678);
      @(negedge clk);
      n_vec++;
      if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}
          !== {2'b11, 4'b0000, 8'd5, 32'h12345678}) begin
         n_err++;
         $display("FAIL store_nomask: got gnt=%b en=%b we=%b addr=%0d wdata=%h, expected 1 1 0000 5 12345678",
                  bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      expect_access(1'b0, 1'b1, 4'b0000, 32'h14, 32'h12345678);
      tick();

      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, (k == 0) ? 32'h10 : 32'h14, 32'hFFFFFFFF);
         @(negedge clk);
         n_vec++;
         if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b11, 4'h0, (k == 0) ? 8'd4 : 8'd5}) begin
            n_err++;
            $display("FAIL load_cmd%0d: got gnt=%b en=%b we=%b addr=%0d, expected 1 1 0 %0d",
                     k, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, 4 + k);
         end
         expect_access(1'b0, 1'b0, 4'hF, (k == 0) ? 32'h10 : 32'h14, 32'h0);
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      tick();
   endtask

   task automatic test_contention();
      logic [1:0] pat [6];
      pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b01;
      pat[3] = 2'b10; pat[4] = 2'b01; pat[5] = 2'b01;
      drive(1'b1, 32'h20, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_vec++;
         if ({bus.if_gnt, bus.d_gnt, bus.mem_addr} !== {pat[k], pat[k][1] ? 8'd8 : 8'd12}) begin
            n_err++;
            $display("FAIL contention%0d: got if/d gnt=%b%b addr=%0d, expected %b",
                     k, bus.if_gnt, bus.d_gnt, bus.mem_addr, pat[k]);
         end
         expect_access(pat[k][1], 1'b0, 4'h0, pat[k][1] ? 32'h20 : 32'h30, 32'h0);
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      tick();
   endtask

   task automatic test_out_of_range();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h400, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b10, 45'd0}) begin
         n_err++;
         $display("FAIL oor_load: got gnt=%b en=%b addr=%0d, expected 1 0 0", bus.d_gnt, bus.mem_en, bus.mem_addr);
      end
      expect_access(1'b0, 1'b0, 4'h0, 32'h400, 32'h0);
      tick();

      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h400, 32'hDEADBEEF);
      @(negedge clk);
      n_vec++;
      if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 45'd0}) begin
         n_err++;
         $display("FAIL oor_store: got gnt=%b en=%b we=%b wdata=%h, expected 1 0 0 0",
                  bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_wdata);
      end
      expect_access(1'b0, 1'b1, 4'hF, 32'h400, 32'hDEADBEEF);
      tick();

      drive(1'b1, 32'hFFFF0008, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_addr} !== {3'b100, 8'd0}) begin
         n_err++;
         $display("FAIL oor_fetch: got gnt=%b%b en=%b addr=%0d, expected 10 0 0",
                  bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_addr);
      end
      expect_access(1'b1, 1'b0, 4'h0, 32'hFFFF0008, 32'h0);
      tick();

      // Word 0 must still hold its original value
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      expect_access(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      tick();
   endtask

   task automatic test_pipeline();
      logic [31:0] addrs [4];
      addrs[0] = 32'h10; addrs[1] = 32'h8; addrs[2] = 32'h18; addrs[3] = 32'hC;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, addrs[k], 32'h0);
         else            drive(1'b1, addrs[k], 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         @(negedge clk);
         n_vec++;
         if ({bus.if_gnt, bus.d_gnt, bus.mem_addr} !== {(k % 2 == 1), (k % 2 == 0), addrs[k][AW+1:2]}) begin
            n_err++;
            $display("FAIL pipe_grant%0d: got gnt=%b%b addr=%0d, expected addr %0d",
                     k, bus.if_gnt, bus.d_gnt, bus.mem_addr, addrs[k][AW+1:2]);
         end
         expect_access(k % 2 == 1, 1'b0, 4'h0, addrs[k], 32'h0);
         tick();
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      tick();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      n_vec++;
      if (bus.if_gnt !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_grant: got if_gnt=%b, expected 1", bus.if_gnt);
      end
      tick();

      reset = 1'b1;
      drive(1'b1, 32'h8, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({bus.if_rvalid, bus.if_gnt, bus.d_gnt} !== 3'b000) begin
         n_err++;
         $display("FAIL rstmid_n1: got rvalid=%b gnt=%b%b, expected 0 00", bus.if_rvalid, bus.if_gnt, bus.d_gnt);
      end
      tick();

      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      n_vec++;
      if ({bus.if_rvalid, dut.starve_cnt, dut.pend_if} !== '0) begin
         n_err++;
         $display("FAIL rstmid_n2: got rvalid=%b starve=%0d pend_if=%b, expected 0 0 0",
                  bus.if_rvalid, dut.starve_cnt, dut.pend_if);
      end
      tick();
   endtask

   task automatic test_idle();
      // Dropped requests with live-looking side inputs must do nothing
      drive(1'b0, 32'h8, 1'b0, 1'b1, 4'hF, 32'h10, 32'h55AA55AA);
      repeat (2) begin
         @(negedge clk);
         n_vec++;
         if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
              bus.if_rvalid, bus.d_rvalid, bus.d_err, bus.if_rdata, bus.d_rdata} !== '0) begin
            n_err++;
            $display("FAIL idle_outputs: got gnt=%b%b en=%b we=%b wdata=%h, expected all 0",
                     bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_wdata);
         end
         tick();
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL pending_responses: got %0d outstanding, expected 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {8'hA5, i[7:0], ~i[7:0], 8'h3C};
      mem[2] = 32'h00100093;
      mem[4] = 32'h11223344;
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      bus.mem_rdata = 32'd0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      test_reset();
      test_fetch();
      test_store_load();
      test_contention();
      test_out_of_range();
      test_pipeline();
      test_reset_mid();
      test_idle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end, expected completion");
      $fatal(1);
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the memory word-address width (256 words).
REQ-002 The block SHALL have parameter STARVE_MAX, default 3, giving the consecutive fetch denials after which fetch wins.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read request; held with stable if_addr until granted.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- if_err  out  1  fetch response is an out-of-range error.
- d_req  in  1  load/store request; held with stable d_* inputs until granted.
- d_we  in  1  1 = store, 0 = load.
- d_wmask  in  4  store byte-lane enables; bit i maps to bits [8i+7:8i].
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  load data.
- d_err  out  1  data response is an out-of-range error.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-004 The block SHALL accept at most one request per cycle; if_gnt and d_gnt SHALL be combinational and never both 1.
REQ-005 Priority SHALL default to data over fetch; fetch SHALL win when starve_cnt == STARVE_MAX and if_req=1.
REQ-006 starve_cnt SHALL behave as follows:
- increment, saturating at STARVE_MAX, in each cycle with if_req=1 and if_gnt=0;
- clear when if_gnt=1 or if_req=0.
REQ-007 The word address SHALL be addr[ADDR_W+1:2]; addr[1:0] SHALL be ignored.
REQ-008 A request is in range when addr[31:ADDR_W+2]==0. In-range handling:
- mem_en=1 and mem_addr = word address in the grant cycle;
- for stores, mem_we=d_wmask and mem_wdata=d_wdata;
- for reads, mem_we=0.
REQ-009 An out-of-range request SHALL still be granted, but mem_en SHALL stay 0 and memory SHALL not be written.
REQ-010 A granted read SHALL produce exactly one response, with rvalid=1 in the cycle after the grant (latency 1):
- in range: rdata = mem_rdata and err=0;
- out of range: rdata=0 and err=1.
REQ-011 A granted store SHALL complete at grant and produce no response:
- in range: d_rvalid is not asserted;
- out of range: d_err=1 and d_rvalid=0 for one cycle.
REQ-012 A store with d_wmask=0 SHALL be granted with mem_en=1 and mem_we=0, and no response.
REQ-013 Back-to-back grants SHALL be allowed every cycle; response owner SHALL be tracked by registered pending flags pend_if and pend_d.
REQ-014 When not rvalid, the rdata outputs SHALL be 0.
REQ-015 When mem_en=0, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-016 If both requests drop before a grant, the block SHALL take no action and no response SHALL be produced.

Reset
REQ-017 While reset=1, these outputs SHALL be 0: all gnt, rvalid, err, rdata and mem_* outputs.
REQ-018 While reset=1, starve_cnt, pend_if and pend_d SHALL be cleared to 0.
REQ-019 Reset asserted in the cycle after a grant SHALL suppress that grant's response; it SHALL never appear afterwards.
REQ-020 The first grant SHALL be possible in the first cycle with reset=0.

Verification
REQ-021 Fetch only: if_req=1, if_addr=0x8, mem word 2 = 0x00100093 -> cycle N: if_gnt=1, mem_addr=2; cycle N+1: if_rvalid=1, if_rdata=0x00100093.
REQ-022 Store then load: d_we=1, d_addr=0x10, d_wmask=4'b0011, d_wdata=0xAABBCCDD, word 4 previously 0x11223344 -> mem_we=0011; a later load of 0x10 returns 0x1122CCDD.
REQ-023 Contention: if_req and d_req both held high for 6 cycles with STARVE_MAX=3 -> grants are d, d, d, if, d, d.
REQ-024 Out of range: d_addr=0x400 load -> d_gnt=1, mem_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0.
REQ-025 Reset mid-operation: fetch granted at cycle N, reset=1 at N+1 -> if_rvalid=0 at N+1 and N+2, and starve_cnt=0.
REQ-026 Pipelining: alternating d load and fetch on four consecutive cycles -> four responses, each one cycle after its grant, each routed to the correct port.
